// File: rtl/keymill_sequencer_if.sv
// APB bus between the keymill sequencer (master) and the keymill coprocessor (slave).
interface keymill_sequencer_if;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;

  modport master (
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_prdata
  );

  modport slave (
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_prdata
  );
endinterface

// File: rtl/keymill_sequencer.sv
// Keymill sequencer: runs a complete keystream job on the keymill APB slave
// (soft reset, key/IV load, start, status poll, stream reads) and forwards
// each keystream word over a valid/ready port.
module keymill_sequencer #(
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               vclk,
  input  logic               vrst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [127:0]       cmd_key,
  input  logic [127:0]       cmd_iv,
  input  logic [CNT_W-1:0]   cmd_nwords,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  keymill_sequencer_if.master apb
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  localparam logic [5:0]  W_CTRL   = 6'd0;
  localparam logic [5:0]  W_STREAM = 6'd1;
  localparam logic [5:0]  W_KEY0   = 6'd1;
  localparam logic [5:0]  W_IV0    = 6'd5;
  localparam logic [31:0] CTRL_SRST  = 32'h0000_0002;
  localparam logic [31:0] CTRL_START = 32'h0000_0001;

  typedef enum logic [3:0] {
    S_IDLE, S_SRST, S_WKEY, S_WIV, S_START, S_POLL, S_READ, S_HOLD, S_FIN
  } state_t;

  state_t             state, state_n;
  logic               access, access_n;
  logic [1:0]         idx, idx_n;
  logic [PW-1:0]      poll_cnt, poll_n;
  logic [CNT_W-1:0]   word_cnt, wcnt_n;
  logic [127:0]       key_q, key_n;
  logic [127:0]       iv_q, iv_n;
  logic [CNT_W-1:0]   nwords_q, nwords_n;
  logic               out_valid_n;
  logic [31:0]        out_data_n;
  logic               err_n;
  logic               xfer_state;
  logic               psel_n, penable_n, pwrite_n;
  logic [5:0]         word_n;
  logic [31:0]        pwdata_n;

  // Next-state, counters and the registered values of every output.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    poll_n      = poll_cnt;
    wcnt_n      = word_cnt;
    key_n       = key_q;
    iv_n        = iv_q;
    nwords_n    = nwords_q;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    err_n       = 1'b0;
    psel_n      = 1'b0;
    penable_n   = 1'b0;
    pwrite_n    = 1'b0;
    word_n      = 6'd0;
    pwdata_n    = 32'h0;

    // APB states alternate SETUP/ACCESS every cycle with no gap
    xfer_state = (state == S_SRST) || (state == S_WKEY) || (state == S_WIV) ||
                 (state == S_START) || (state == S_POLL) || (state == S_READ);
    access_n = xfer_state ? !access : 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          key_n    = cmd_key;
          iv_n     = cmd_iv;
          nwords_n = cmd_nwords;
          wcnt_n   = '0;
          poll_n   = '0;
          idx_n    = 2'd0;
          state_n  = (cmd_nwords == '0) ? S_FIN : S_SRST;
        end
      end
      S_SRST: begin
        if (access) begin
          idx_n   = 2'd0;
          state_n = S_WKEY;
        end
      end
      S_WKEY: begin
        if (access) begin
          idx_n = idx + 2'd1;
          if (idx == 2'd3) state_n = S_WIV;
        end
      end
      S_WIV: begin
        if (access) begin
          idx_n = idx + 2'd1;
          if (idx == 2'd3) state_n = S_START;
        end
      end
      S_START: begin
        if (access) state_n = S_POLL;
      end
      S_POLL: begin
        if (access) begin
          poll_n = poll_cnt + PW'(1);
          if (apb.m_prdata[31:30] == 2'b00) begin
            state_n = S_READ;
          end else if ((poll_cnt + PW'(1)) >= POLL_LIMIT) begin
            state_n = S_FIN;
            err_n   = 1'b1;
          end
        end
      end
      S_READ: begin
        if (access) begin
          out_data_n  = apb.m_prdata;
          out_valid_n = 1'b1;
          state_n     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          wcnt_n      = word_cnt + CNT_W'(1);
          state_n     = ((word_cnt + CNT_W'(1)) == nwords_q) ? S_FIN : S_READ;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Bus values for the cycle being entered
    case (state_n)
      S_SRST: begin
        psel_n   = 1'b1;
        pwrite_n = 1'b1;
        word_n   = W_CTRL;
        pwdata_n = CTRL_SRST;
      end
      S_WKEY: begin
        psel_n   = 1'b1;
        pwrite_n = 1'b1;
        word_n   = W_KEY0 + {4'd0, idx_n};
        pwdata_n = key_n[{idx_n, 5'd0} +: 32];
      end
      S_WIV: begin
        psel_n   = 1'b1;
        pwrite_n = 1'b1;
        word_n   = W_IV0 + {4'd0, idx_n};
        pwdata_n = iv_n[{idx_n, 5'd0} +: 32];
      end
      S_START: begin
        psel_n   = 1'b1;
        pwrite_n = 1'b1;
        word_n   = W_CTRL;
        pwdata_n = CTRL_START;
      end
      S_POLL: begin
        psel_n = 1'b1;
        word_n = W_CTRL;
      end
      S_READ: begin
        psel_n = 1'b1;
        word_n = W_STREAM;
      end
      default: begin
        psel_n = 1'b0;
      end
    endcase
    penable_n = psel_n && access_n;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge vclk) begin
    if (vrst) begin
      state         <= S_IDLE;
      access        <= 1'b0;
      idx           <= 2'd0;
      poll_cnt      <= '0;
      word_cnt      <= '0;
      key_q         <= '0;
      iv_q          <= '0;
      nwords_q      <= '0;
      out_valid     <= 1'b0;
      out_data      <= 32'h0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      apb.m_psel    <= 1'b0;
      apb.m_penable <= 1'b0;
      apb.m_pwrite  <= 1'b0;
      apb.m_paddr   <= 32'h0;
      apb.m_pwdata  <= 32'h0;
    end else begin
      state         <= state_n;
      access        <= access_n;
      idx           <= idx_n;
      poll_cnt      <= poll_n;
      word_cnt      <= wcnt_n;
      key_q         <= key_n;
      iv_q          <= iv_n;
      nwords_q      <= nwords_n;
      out_valid     <= out_valid_n;
      out_data      <= out_data_n;
      cmd_ready     <= (state_n == S_IDLE);
      busy          <= (state_n != S_IDLE);
      done          <= (state_n == S_FIN);
      err           <= err_n;
      apb.m_psel    <= psel_n;
      apb.m_penable <= penable_n;
      apb.m_pwrite  <= pwrite_n;
      apb.m_paddr   <= {24'h0, word_n, 2'b00};
      apb.m_pwdata  <= pwdata_n;
    end
  end

endmodule

// File: doc/keymill_sequencer.md
Name: keymill_sequencer

Overview:
APB master that drives one keymill coprocessor slave through a full keystream job with no CPU involvement. On a command it soft-resets the core, loads the 128-bit key and 128-bit IV, starts generation and polls status until the core is ready. It then reads a requested number of 32-bit keystream words and hands each one to a downstream consumer over a valid/ready port. It sits between a DMA/crypto front-end and the keymill APB slave.

Parameters:
POLL_MAX, 1024, max status reads per job before timeout (≥1)
CNT_W, 16, width of word-count field

Ports:
vclk  in  1  clock
vrst  in  1  synchronous active-high reset
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_key  in  128  key, sampled on accept
cmd_iv  in  128  IV, sampled on accept
cmd_nwords  in  CNT_W  keystream words to read
out_valid  out  1  keystream word available
out_ready  in  1  consumer accepts word
out_data  out  32  keystream word
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse at job end
err  out  1  1-cycle pulse with done on poll timeout
m_psel  out  1  APB select
m_penable  out  1  APB enable
m_pwrite  out  1  APB write
m_paddr  out  32  APB byte address; only [7:2] nonzero
m_pwdata  out  32  APB write data
m_prdata  in  32  APB read data

Behaviour:
- Reset (vrst=1 at edge): state IDLE; all outputs 0 except cmd_ready=1; out_data=0; counters cleared. Reset mid-job abandons the transfer immediately; no APB cleanup.
- APB transfer = 2 cycles, zero wait states: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1). Addr/write/wdata are stable across both cycles. Read data is sampled at the edge ending ACCESS. Back-to-back transfers have no idle cycle between them. psel=penable=0 outside transfers.
- Register map (word index = paddr[7:2]):
  - 0: write = ctrl (bit0 start, bit1 soft reset); read = status, ready when [31:30]==00.
  - 1..4: key, word k = cmd_key[32(k-1)+:32].
  - 5..8: IV, word k = cmd_iv[32(k-5)+:32].
  - 1 (read): stream out.
- Accept on cmd_valid&cmd_ready; key/iv/nwords latched.
  - cmd_nwords==0: done pulses next cycle, no APB traffic, return to IDLE.
- FSM: IDLE -> SRST (write 0x00000002 to word 0) -> WKEY (words 1,2,3,4 in order) -> WIV (words 5..8) -> START (write 0x00000001 to word 0) -> POLL -> READ <-> HOLD -> FIN -> IDLE.
- Timing: the SRST SETUP cycle immediately follows the accept edge. The first POLL SETUP occurs 20 cycles after accept.
- POLL: read word 0.
  - If sampled [31:30]==00: go to READ.
  - Else, if poll count < POLL_MAX: reissue next cycle.
  - Else (POLL_MAX-th read not ready): go to FIN with err.
- READ: read word 1; capture m_prdata into out_data; out_valid=1 from the following cycle; go to HOLD. out_data is stable while out_valid&!out_ready.
- HOLD: wait for out_valid&out_ready.
  - On handshake, out_valid drops next cycle and the word counter increments.
  - If counter==nwords: go to FIN; else the next READ SETUP is issued the cycle after the handshake.
- Status is not re-polled between stream words.
- FIN: done=1 for one cycle (err=1 with it on timeout); return to IDLE. cmd_ready is high the next cycle.
- cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- Reset, then key=0x01234567_89ABCDEF_01234567_89ABCDEF, iv same, nwords=2 -> exact APB trace: SRST wdata 0x2, key words 1..4 = 0x89ABCDEF,0x01234567,0x89ABCDEF,0x01234567, same for IV on 5..8, start 0x1; first poll SETUP at accept+20.
- Slave status [31:30]=11 for 3 polls then 00, stream words 0xA5A5A5A5, 0x5A5A5A5A, out_ready=1 -> out_data shows both words in order; done pulses once; err=0; 4 poll transfers.
- out_ready held 0 for 10 cycles after first out_valid -> out_data stable, no APB activity during hold; resumes the cycle after handshake.
- POLL_MAX=4, status never ready -> exactly 4 poll reads, then done=err=1 same cycle, no stream reads, cmd_ready=1 next cycle.
- nwords=0 -> done one cycle after accept, psel never asserted.
- vrst asserted during WIV -> next cycle psel=penable=0, busy=0, cmd_ready=1; a new job runs its full correct sequence.
